hmac_ctrl: RTL and testbench
============================

HMAC_CTRL -- requirements
Module: hmac_ctrl

Interface
REQ-001 Parameters: none; all widths fixed (512-bit block, 256-bit digest).
REQ-002 One clock; reset is synchronous and active-high. Ports: clk_i input 1, rising-edge clock; rst_i input 1, synchronous active-high reset.
REQ-003 Request side:
- key_i input 512: K0, byte 0 at [511:504]; caller zero-pads.
- msg_i input 512: message, byte 0 at [511:504].
- msg_len_i input 6: message length in bytes, 0..63.
- v_i input 1: request valid.
- r_o output 1: request ready.
REQ-004 Result side:
- prf_o output 256: HMAC-SHA256 digest, big-endian.
- v_o output 1: result valid.
- r_i input 1: result ready.
REQ-005 SHA-256 core side:
- core_block_o output 512: block to compress.
- core_init_o output 1: 1 = start from SHA-256 IV; 0 = chain from the previous digest.
- core_v_o output 1: block valid.
- core_r_i input 1: core ready.
- core_digest_i input 256: running digest.
- core_v_i input 1: digest valid.
- core_r_o output 1: digest ready.

Function
REQ-006 States: IDLE, I_KEY, I_MSG, I_PAD, O_KEY, O_DIG, DONE. Each non-IDLE/DONE state issues exactly one core block.
REQ-007 Each issuing state has two phases.
- Send: core_v_o=1 until core_v_o&&core_r_i; then Wait.
- Wait: core_r_o=1 until core_v_i; the digest is captured, then the next state is entered.
REQ-008 IDLE: r_o=1. On v_i&&r_o, key_i, msg_i and msg_len_i are registered and I_KEY is entered. Inputs are ignored at all other times.
REQ-009 I_KEY: block = K0 XOR {64{8'h36}}; core_init_o=1.
REQ-010 I_MSG: block = msg bytes [0..len-1], then 0x80 at byte len, remaining bytes zero.
- len<=55: bytes 56..63 = 64-bit big-endian (64+len)*8; next state O_KEY.
- len>=56: no length field; next state I_PAD.
REQ-011 Message bytes at index >= len are masked to zero, never forwarded.
REQ-012 I_PAD: block = 56 zero bytes, then 64-bit big-endian (64+len)*8; next state O_KEY.
REQ-013 The digest at the end of the inner hash is held in an inner-digest register.
REQ-014 O_KEY: block = K0 XOR {64{8'h5c}}; core_init_o=1.
REQ-015 O_DIG: block = inner digest (32 bytes), then 0x80, then zeros, then 64-bit length 0x300.
REQ-016 At the end of O_DIG, core_digest_i is registered into prf_o and DONE is entered.
REQ-017 DONE: v_o=1. prf_o holds stable until v_o&&r_i; then IDLE.
REQ-018 r_o is asserted only in IDLE, and never in the same cycle as v_o.
REQ-019 core_init_o is 0 in I_MSG, I_PAD and O_DIG. It is meaningful only while core_v_o=1.
REQ-020 Core stalls: core_r_i or core_v_i low for any number of cycles holds the current state and its outputs unchanged.
REQ-021 Block count per request: 4 when len<=55, 5 when len>=56.
REQ-022 Minimum latency from accept to v_o is 2 cycles per block plus 1, when the core responds in zero wait cycles.

Reset
REQ-023 rst_i in any state, including mid-block, forces IDLE on the next edge.
REQ-024 Output values after reset: r_o=1; v_o, core_v_o and core_r_o = 0; prf_o = 0; internal registers = 0.
REQ-025 The SHA-256 core is reset by the same rst_i; no block is issued in the reset cycle.

Verification
REQ-026 Key "Jefe" zero-padded, msg "what do ya want for nothing?", len 28, behavioural SHA-256 core -> prf_o = 5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843, with 4 core blocks.
REQ-027 len=55 vs len=56 -> 4 vs 5 core blocks. The final inner block carries length 0x3B8 vs 0x3C0 respectively, and 0x80 at byte 55 vs 56.
REQ-028 len=0 -> I_MSG block = 0x80 followed by zeros and length 0x200. msg_i bits are all ones, yet no message byte is forwarded.
REQ-029 Random core_r_i/core_v_i stalls of 0-7 cycles plus r_i held low 10 cycles -> prf_o unchanged and v_o held. r_o=0 throughout. Result matches the REQ-026 value.
REQ-030 rst_i pulsed during I_MSG Wait -> next cycle IDLE, r_o=1, core_v_o=0. A subsequent request completes with the correct digest.
REQ-031 Back-to-back requests with v_i held high -> the second request is accepted only in the cycle after v_o&&r_i. Both digests are correct.

Source files
------------

// File: rtl/hmac_ctrl.sv
// HMAC-SHA256 sequencer: turns one (key, message <= 63 bytes) request into the
// inner and outer block stream for an external SHA-256 compression core.
module hmac_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [511:0] key_i,
    input  logic [511:0] msg_i,
    input  logic [5:0]   msg_len_i,
    input  logic         v_i,
    output logic         r_o,
    output logic [255:0] prf_o,
    output logic         v_o,
    input  logic         r_i,
    output logic [511:0] core_block_o,
    output logic         core_init_o,
    output logic         core_v_o,
    input  logic         core_r_i,
    input  logic [255:0] core_digest_i,
    input  logic         core_v_i,
    output logic         core_r_o
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        I_KEY = 3'd1,
        I_MSG = 3'd2,
        I_PAD = 3'd3,
        O_KEY = 3'd4,
        O_DIG = 3'd5,
        DONE  = 3'd6
    } state_e;

    localparam logic [511:0] IPAD = {64{8'h36}};
    localparam logic [511:0] OPAD = {64{8'h5c}};

    state_e       state_q, state_d;
    logic [511:0] key_q, key_d;
    logic [511:0] msg_q, msg_d;
    logic [5:0]   len_q, len_d;
    logic [511:0] block_q, block_d;
    logic [255:0] inner_q, inner_d;
    logic [255:0] prf_q, prf_d;
    logic         init_q, init_d;
    logic         core_v_q, core_v_d;
    logic         core_r_q, core_r_d;
    logic         r_q, r_d;
    logic         v_q, v_d;

    // Inner-hash bit length: one key block plus len message bytes.
    function automatic logic [63:0] inner_bits(input logic [5:0] len);
        return (64'd64 + 64'(len)) * 64'd8;
    endfunction

    function automatic logic [511:0] build_block(input state_e st, input logic [511:0] key,
                                                 input logic [511:0] msg, input logic [5:0] len,
                                                 input logic [255:0] inner);
        logic [511:0] blk;
        logic [9:0]   sh;
        sh = {1'b0, len, 3'b000};
        case (st)
            I_KEY:   blk = key ^ IPAD;
            I_MSG: begin
                // keep only the first len bytes, then the 0x80 terminator at byte len
                blk = (msg & ~({512{1'b1}} >> sh)) | ({8'h80, 504'd0} >> sh);
                blk[63:0] = (len <= 6'd55) ? inner_bits(len) : blk[63:0];
            end
            I_PAD:   blk = {448'd0, inner_bits(len)};
            O_KEY:   blk = key ^ OPAD;
            O_DIG:   blk = {inner, 8'h80, 184'd0, 64'h300};
            default: blk = 512'd0;
        endcase
        return blk;
    endfunction

    function automatic state_e after(input state_e st, input logic [5:0] len);
        state_e nx;
        case (st)
            I_KEY:   nx = I_MSG;
            I_MSG:   nx = (len <= 6'd55) ? O_KEY : I_PAD;
            I_PAD:   nx = O_KEY;
            O_KEY:   nx = O_DIG;
            O_DIG:   nx = DONE;
            default: nx = IDLE;
        endcase
        return nx;
    endfunction

    // Next-state and next-output computation for the request sequencer.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        msg_d    = msg_q;
        len_d    = len_q;
        block_d  = block_q;
        inner_d  = inner_q;
        prf_d    = prf_q;
        init_d   = init_q;
        core_v_d = core_v_q;
        core_r_d = core_r_q;
        r_d      = r_q;
        v_d      = v_q;
        case (state_q)
            IDLE: begin
                if (v_i && r_q) begin
                    state_d  = I_KEY;
                    key_d    = key_i;
                    msg_d    = msg_i;
                    len_d    = msg_len_i;
                    block_d  = build_block(I_KEY, key_i, msg_i, msg_len_i, inner_q);
                    init_d   = 1'b1;
                    core_v_d = 1'b1;
                    r_d      = 1'b0;
                end else begin
                    r_d = 1'b1;
                end
            end
            I_KEY, I_MSG, I_PAD, O_KEY, O_DIG: begin
                if (core_v_q && core_r_i) begin
                    core_v_d = 1'b0;
                    core_r_d = 1'b1;
                end else if (core_r_q && core_v_i) begin
                    core_r_d = 1'b0;
                    state_d  = after(state_q, len_q);
                    if (state_q == O_DIG) begin
                        prf_d = core_digest_i;
                        v_d   = 1'b1;
                    end else begin
                        inner_d  = (state_d == O_KEY) ? core_digest_i : inner_q;
                        init_d   = (state_d == O_KEY);
                        core_v_d = 1'b1;
                        block_d  = build_block(state_d, key_q, msg_q, len_q, inner_d);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DONE: begin
                if (v_q && r_i) begin
                    state_d = IDLE;
                    v_d     = 1'b0;
                    r_d     = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d  = IDLE;
                core_v_d = 1'b0;
                core_r_d = 1'b0;
                v_d      = 1'b0;
                r_d      = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            key_q    <= 512'd0;
            msg_q    <= 512'd0;
            len_q    <= 6'd0;
            block_q  <= 512'd0;
            inner_q  <= 256'd0;
            prf_q    <= 256'd0;
            init_q   <= 1'b0;
            core_v_q <= 1'b0;
            core_r_q <= 1'b0;
            r_q      <= 1'b1;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            msg_q    <= msg_d;
            len_q    <= len_d;
            block_q  <= block_d;
            inner_q  <= inner_d;
            prf_q    <= prf_d;
            init_q   <= init_d;
            core_v_q <= core_v_d;
            core_r_q <= core_r_d;
            r_q      <= r_d;
            v_q      <= v_d;
        end
    end

    assign r_o          = r_q;
    assign v_o          = v_q;
    assign prf_o        = prf_q;
    assign core_block_o = block_q;
    assign core_init_o  = init_q;
    assign core_v_o     = core_v_q;
    assign core_r_o     = core_r_q;

endmodule

// File: tb/tb_hmac_ctrl.sv
// Bench for hmac_ctrl: a behavioural SHA-256 core with random stalls, and an
// HMAC reference built from generic SHA-256 padding over byte queues.
module tb_hmac_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_i, v_i, r_i, core_r_i, core_v_i;
    logic [511:0] key_i, msg_i;
    logic [5:0]   msg_len_i;
    logic         r_o, v_o, core_init_o, core_v_o, core_r_o;
    logic [255:0] prf_o, core_digest_i;
    logic [511:0] core_block_o;

    hmac_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .key_i(key_i), .msg_i(msg_i), .msg_len_i(msg_len_i),
        .v_i(v_i), .r_o(r_o), .prf_o(prf_o), .v_o(v_o), .r_i(r_i),
        .core_block_o(core_block_o), .core_init_o(core_init_o), .core_v_o(core_v_o),
        .core_r_i(core_r_i), .core_digest_i(core_digest_i), .core_v_i(core_v_i),
        .core_r_o(core_r_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] JEFE_KEY = {32'h4a656665, 480'd0};
    localparam logic [511:0] JEFE_MSG = {224'h7768617420646f2079612077616e7420666f72206e6f7468696e673f, 288'd0};
    localparam logic [255:0] JEFE_PRF =
        256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   bytes_q [$];
    logic [511:0] exp_blk [$];
    logic         exp_init [$];

    task automatic hash_bytes(output logic [255:0] dig);
        logic [7:0]   buf_q [$];
        logic [511:0] blk;
        logic [63:0]  bitlen;
        buf_q  = bytes_q;
        bitlen = 64'(buf_q.size()) * 64'd8;
        buf_q.push_back(8'h80);
        while ((buf_q.size() % 64) != 56) buf_q.push_back(8'h00);
        for (int i = 7; i >= 0; i--) buf_q.push_back(bitlen[i*8 +: 8]);
        dig = SHA_IV;
        for (int bi = 0; bi < buf_q.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = buf_q[bi*64 + j];
            exp_blk.push_back(blk);
            exp_init.push_back(bi == 0);
            dig = sha256_compress(dig, blk);
        end
    endtask

    task automatic hmac_ref(input logic [511:0] k, input logic [511:0] m, input logic [5:0] l,
                            output logic [255:0] dig);
        logic [255:0] inner;
        exp_blk.delete();
        exp_init.delete();
        bytes_q.delete();
        for (int i = 0; i < 64; i++) bytes_q.push_back(k[511 - 8*i -: 8] ^ 8'h36);
        for (int i = 0; i < int'(l); i++) bytes_q.push_back(m[511 - 8*i -: 8]);
        hash_bytes(inner);
        bytes_q.delete();
        for (int i = 0; i < 64; i++) bytes_q.push_back(k[511 - 8*i -: 8] ^ 8'h5c);
        for (int i = 0; i < 32; i++) bytes_q.push_back(inner[255 - 8*i -: 8]);
        hash_bytes(dig);
    endtask

    // ---------------- behavioural SHA-256 core ----------------
    int unsigned  max_stall = 0;
    logic [511:0] got_blk [$];
    logic         got_init [$];

    initial begin : core_model
        logic         hs_in, hs_out, rst_s, init_s;
        logic [511:0] blk_s;
        logic [255:0] chain;
        int           busy, dly, rdly;
        core_r_i = 1'b0; core_v_i = 1'b0; core_digest_i = '0;
        chain = '0; busy = 0; dly = 0; rdly = 0;
        forever begin
            @(negedge clk_i); #1;
            hs_in  = core_v_o && core_r_i;
            hs_out = core_v_i && core_r_o;
            rst_s  = rst_i;
            blk_s  = core_block_o;
            init_s = core_init_o;
            @(posedge clk_i); #1;
            if (rst_s) begin
                busy = 0; core_v_i = 1'b0; core_r_i = 1'b0; rdly = 0;
            end else begin
                if (hs_out) begin
                    core_v_i = 1'b0; busy = 0; rdly = $urandom_range(max_stall, 0);
                end
                if (hs_in) begin
                    chain = sha256_compress(init_s ? SHA_IV : chain, blk_s);
                    got_blk.push_back(blk_s);
                    got_init.push_back(init_s);
                    busy = 1; core_r_i = 1'b0; dly = $urandom_range(max_stall, 0);
                end
            end
            if (busy != 0 && !core_v_i) begin
                if (dly == 0) begin core_v_i = 1'b1; core_digest_i = chain; end
                else dly--;
            end
            if (busy == 0) begin
                if (rdly == 0) core_r_i = 1'b1;
                else begin core_r_i = 1'b0; rdly--; end
            end
        end
    end

    // One full request: accept, wait for result, hold r_i low, release, compare blocks.
    task automatic run_req(input string tag, input logic [511:0] k, input logic [511:0] m,
                           input logic [5:0] l, input int stall, input int hold,
                           output logic [255:0] got);
        int cyc;
        logic r_seen;
        logic [255:0] ref_dig;
        max_stall = stall;
        hmac_ref(k, m, l, ref_dig);
        got_blk.delete();
        got_init.delete();
        @(negedge clk_i);
        key_i = k; msg_i = m; msg_len_i = l; v_i = 1'b1;
        cyc = 0;
        while (!r_o && cyc < 100) begin @(negedge clk_i); cyc++; end
        chk({tag, " accept"}, 512'(r_o), 512'(1'b1));
        @(negedge clk_i);
        v_i = 1'b0; key_i = rand512(); msg_i = rand512(); msg_len_i = 6'($urandom);
        cyc = 0; r_seen = 1'b0;
        while (!v_o && cyc < 3000) begin r_seen |= r_o; @(negedge clk_i); cyc++; end
        chk({tag, " result valid"}, 512'(v_o), 512'(1'b1));
        chk({tag, " r_o while busy"}, 512'(r_seen), 512'(1'b0));
        chk({tag, " digest"}, 512'(prf_o), 512'(ref_dig));
        got = prf_o;
        for (int h = 0; h < hold; h++) begin
            chk({tag, " hold"}, 512'({prf_o, v_o, r_o}), 512'({ref_dig, 1'b1, 1'b0}));
            @(negedge clk_i);
        end
        r_i = 1'b1;
        @(negedge clk_i);
        r_i = 1'b0;
        chk({tag, " release"}, 512'({v_o, r_o}), 512'({1'b0, 1'b1}));
        chk({tag, " block count"}, 512'(got_blk.size()), 512'(exp_blk.size()));
        for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
            chk($sformatf("%s block %0d", tag, i), got_blk[i], exp_blk[i]);
            chk($sformatf("%s init %0d", tag, i), 512'(got_init[i]), 512'(exp_init[i]));
        end
    endtask

    typedef struct {
        logic [511:0] key;
        logic [511:0] msg;
        logic [5:0]   len;
        int           stall;
        int           hold;
        int           exp_blocks;
        logic         has_prf;
        logic [255:0] exp_prf;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        logic [255:0] got, dig_b;
        logic [511:0] blk, exp;
        logic [511:0] key_b, msg_b;
        logic [5:0]   len_b, len_r;
        int cyc, n_acc, n_done, pend;
        int acc_cyc [2];
        int done_cyc [2];
        logic [255:0] dig [2];
        logic overlap;

        vecs[0] = '{JEFE_KEY, JEFE_MSG, 6'd28, 0, 0, 4, 1'b1, JEFE_PRF};
        vecs[1] = '{rand512(), rand512(), 6'd55, 0, 1, 4, 1'b0, 256'd0};
        vecs[2] = '{rand512(), rand512(), 6'd56, 0, 1, 5, 1'b0, 256'd0};
        vecs[3] = '{rand512(), {512{1'b1}}, 6'd0, 1, 0, 4, 1'b0, 256'd0};
        vecs[4] = '{{512{1'b1}}, rand512(), 6'd63, 3, 2, 5, 1'b0, 256'd0};
        vecs[5] = '{JEFE_KEY, JEFE_MSG, 6'd28, 7, 10, 4, 1'b1, JEFE_PRF};

        rst_i = 1'b1; v_i = 1'b0; r_i = 1'b0;
        key_i = '0; msg_i = '0; msg_len_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset outputs", 512'({r_o, v_o, core_v_o, core_r_o}), 512'(4'b1000));
        chk("reset prf", 512'(prf_o), 512'd0);
        rst_i = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_req($sformatf("vec%0d", v), vecs[v].key, vecs[v].msg, vecs[v].len,
                    vecs[v].stall, vecs[v].hold, got);
            chk($sformatf("vec%0d blocks", v), 512'(got_blk.size()), 512'(vecs[v].exp_blocks));
            if (vecs[v].has_prf) chk($sformatf("vec%0d known prf", v), 512'(got), 512'(vecs[v].exp_prf));
            if (got_blk.size() >= 3) begin
                blk = got_blk[1];
                if (vecs[v].len == 6'd55) begin
                    chk("len55 length field", 512'(blk[63:0]), 512'(64'h3b8));
                    chk("len55 pad byte", 512'(blk[511 - 8*55 -: 8]), 512'(8'h80));
                end
                if (vecs[v].len == 6'd56) begin
                    chk("len56 pad byte", 512'(blk[511 - 8*56 -: 8]), 512'(8'h80));
                    blk = got_blk[2];
                    chk("len56 length field", 512'(blk[63:0]), 512'(64'h3c0));
                end
                if (vecs[v].len == 6'd0) begin
                    exp = {8'h80, 440'd0, 64'h200};
                    chk("len0 msg block", blk, exp);
                end
            end
        end

        for (int n = 0; n < 10; n++) begin
            len_r = 6'($urandom_range(63, 0));
            run_req($sformatf("rand%0d", n), rand512(), rand512(), len_r,
                    $urandom_range(3, 0), $urandom_range(2, 0), got);
            chk($sformatf("rand%0d blocks", n), 512'(got_blk.size()),
                512'((len_r <= 6'd55) ? 4 : 5));
        end

        // reset in the wait phase of the message block
        max_stall = 0;
        got_blk.delete();
        got_init.delete();
        @(negedge clk_i);
        key_i = JEFE_KEY; msg_i = JEFE_MSG; msg_len_i = 6'd28; v_i = 1'b1;
        cyc = 0;
        while (!r_o && cyc < 100) begin @(negedge clk_i); cyc++; end
        @(negedge clk_i);
        v_i = 1'b0;
        cyc = 0;
        while (!(got_blk.size() == 2 && core_r_o) && cyc < 200) begin @(negedge clk_i); cyc++; end
        chk("rst reached msg wait", 512'(core_r_o), 512'(1'b1));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst mid-block", 512'({r_o, v_o, core_v_o, core_r_o}), 512'(4'b1000));
        run_req("post-reset", JEFE_KEY, JEFE_MSG, 6'd28, 0, 0, got);
        chk("post-reset known prf", 512'(got), 512'(JEFE_PRF));

        // back-to-back requests with v_i and r_i held high
        key_b = rand512(); msg_b = rand512(); len_b = 6'($urandom_range(63, 0));
        hmac_ref(key_b, msg_b, len_b, dig_b);
        max_stall = 1;
        @(negedge clk_i);
        key_i = JEFE_KEY; msg_i = JEFE_MSG; msg_len_i = 6'd28; v_i = 1'b1; r_i = 1'b1;
        n_acc = 0; n_done = 0; pend = 0; cyc = 0; overlap = 1'b0;
        acc_cyc = '{0, 0}; done_cyc = '{0, 0}; dig = '{256'd0, 256'd0};
        while (n_done < 2 && cyc < 3000) begin
            if (pend != 0) begin
                if (n_acc == 1) begin key_i = key_b; msg_i = msg_b; msg_len_i = len_b; end
                else v_i = 1'b0;
                pend = 0;
            end
            if (v_o && r_o) overlap = 1'b1;
            if (r_o && v_i && n_acc < 2) begin acc_cyc[n_acc] = cyc; n_acc++; pend = 1; end
            if (v_o && r_i) begin dig[n_done] = prf_o; done_cyc[n_done] = cyc; n_done++; end
            @(negedge clk_i);
            cyc++;
        end
        v_i = 1'b0; r_i = 1'b0;
        chk("b2b completions", 512'(n_done), 512'(2));
        chk("b2b first digest", 512'(dig[0]), 512'(JEFE_PRF));
        chk("b2b second digest", 512'(dig[1]), 512'(dig_b));
        chk("b2b second accept cycle", 512'(acc_cyc[1]), 512'(done_cyc[0] + 1));
        chk("b2b r_o with v_o", 512'(overlap), 512'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
